// File: rtl/dca_matrix_tile_sched_pkg.sv
// Shared types and default field widths for the DCA tiled-GEMM sequencer.
package dca_matrix_tile_sched_pkg;

  localparam int DEF_BW_ADDR        = 32;
  localparam int DEF_BW_TILE_CNT    = 8;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_BW_OUTSTANDING = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dca_matrix_tile_addr_gen.sv
// m/n/k tile counters with incrementally maintained A/B/C tile addresses.
module dca_matrix_tile_addr_gen
  import dca_matrix_tile_sched_pkg::*;
#(
  parameter int BW_ADDR     = DEF_BW_ADDR,
  parameter int BW_TILE_CNT = DEF_BW_TILE_CNT
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   load_i,
  input  logic                   advance_i,
  input  logic [BW_TILE_CNT-1:0] m_tiles_i,
  input  logic [BW_TILE_CNT-1:0] n_tiles_i,
  input  logic [BW_TILE_CNT-1:0] k_tiles_i,
  input  logic [BW_ADDR-1:0]     a_base_i,
  input  logic [BW_ADDR-1:0]     b_base_i,
  input  logic [BW_ADDR-1:0]     c_base_i,
  input  logic [BW_ADDR-1:0]     a_mstride_i,
  input  logic [BW_ADDR-1:0]     a_kstride_i,
  input  logic [BW_ADDR-1:0]     b_kstride_i,
  input  logic [BW_ADDR-1:0]     b_nstride_i,
  input  logic [BW_ADDR-1:0]     c_mstride_i,
  input  logic [BW_ADDR-1:0]     c_nstride_i,
  output logic [BW_ADDR-1:0]     a_addr_o,
  output logic [BW_ADDR-1:0]     b_addr_o,
  output logic [BW_ADDR-1:0]     c_addr_o,
  output logic                   k_first_o,
  output logic                   k_wrap_o,
  output logic                   n_wrap_o,
  output logic                   last_o
);

  logic [BW_TILE_CNT-1:0] m_max_q, n_max_q, k_max_q, m_max_d, n_max_d, k_max_d;
  logic [BW_TILE_CNT-1:0] m_q, n_q, k_q, m_d, n_d, k_d;
  logic [BW_ADDR-1:0] b_base_q, a_ms_q, a_ks_q, b_ks_q, b_ns_q, c_ms_q, c_ns_q;
  logic [BW_ADDR-1:0] b_base_d, a_ms_d, a_ks_d, b_ks_d, b_ns_d, c_ms_d, c_ns_d;
  logic [BW_ADDR-1:0] a_row_q, a_q, b_row_q, b_q, c_row_q, c_q;
  logic [BW_ADDR-1:0] a_row_d, a_d, b_row_d, b_d, c_row_d, c_d;
  logic m_wrap;

  assign k_wrap_o  = (k_q == k_max_q);
  assign n_wrap_o  = (n_q == n_max_q);
  assign m_wrap    = (m_q == m_max_q);
  assign last_o    = k_wrap_o & n_wrap_o & m_wrap;
  assign k_first_o = (k_q == '0);
  assign a_addr_o  = a_q;
  assign b_addr_o  = b_q;
  assign c_addr_o  = c_q;

  always_comb begin
    m_max_d = m_max_q; n_max_d = n_max_q; k_max_d = k_max_q;
    m_d = m_q; n_d = n_q; k_d = k_q;
    b_base_d = b_base_q;
    a_ms_d = a_ms_q; a_ks_d = a_ks_q; b_ks_d = b_ks_q;
    b_ns_d = b_ns_q; c_ms_d = c_ms_q; c_ns_d = c_ns_q;
    a_row_d = a_row_q; a_d = a_q; b_row_d = b_row_q;
    b_d = b_q; c_row_d = c_row_q; c_d = c_q;
    if (load_i) begin
      m_max_d = m_tiles_i - BW_TILE_CNT'(1);
      n_max_d = n_tiles_i - BW_TILE_CNT'(1);
      k_max_d = k_tiles_i - BW_TILE_CNT'(1);
      m_d = '0; n_d = '0; k_d = '0;
      b_base_d = b_base_i;
      a_ms_d = a_mstride_i; a_ks_d = a_kstride_i; b_ks_d = b_kstride_i;
      b_ns_d = b_nstride_i; c_ms_d = c_mstride_i; c_ns_d = c_nstride_i;
      a_row_d = a_base_i; a_d = a_base_i;
      b_row_d = b_base_i; b_d = b_base_i;
      c_row_d = c_base_i; c_d = c_base_i;
    end else if (advance_i) begin
      if (!k_wrap_o) begin
        k_d = k_q + BW_TILE_CNT'(1);
        a_d = a_q + a_ks_q;
        b_d = b_q + b_ks_q;
      end else begin
        // k restarts: A returns to its row start, B to its column start
        k_d = '0;
        if (!n_wrap_o) begin
          n_d     = n_q + BW_TILE_CNT'(1);
          a_d     = a_row_q;
          b_row_d = b_row_q + b_ns_q;
          b_d     = b_row_q + b_ns_q;
          c_d     = c_q + c_ns_q;
        end else begin
          n_d     = '0;
          m_d     = m_wrap ? '0 : m_q + BW_TILE_CNT'(1);
          a_row_d = a_row_q + a_ms_q;
          a_d     = a_row_q + a_ms_q;
          b_row_d = b_base_q;
          b_d     = b_base_q;
          c_row_d = c_row_q + c_ms_q;
          c_d     = c_row_q + c_ms_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      m_max_q <= '0; n_max_q <= '0; k_max_q <= '0;
      m_q <= '0; n_q <= '0; k_q <= '0;
      b_base_q <= '0;
      a_ms_q <= '0; a_ks_q <= '0; b_ks_q <= '0;
      b_ns_q <= '0; c_ms_q <= '0; c_ns_q <= '0;
      a_row_q <= '0; a_q <= '0; b_row_q <= '0;
      b_q <= '0; c_row_q <= '0; c_q <= '0;
    end else begin
      m_max_q <= m_max_d; n_max_q <= n_max_d; k_max_q <= k_max_d;
      m_q <= m_d; n_q <= n_d; k_q <= k_d;
      b_base_q <= b_base_d;
      a_ms_q <= a_ms_d; a_ks_q <= a_ks_d; b_ks_q <= b_ks_d;
      b_ns_q <= b_ns_d; c_ms_q <= c_ms_d; c_ns_q <= c_ns_d;
      a_row_q <= a_row_d; a_q <= a_d; b_row_q <= b_row_d;
      b_q <= b_d; c_row_q <= c_row_d; c_q <= c_d;
    end
  end

endmodule

// File: rtl/dca_matrix_tile_sched.sv
// Tiled-GEMM sequencer: walks m/n/k tiles, issues MAC instructions, bounds in-flight count.
module dca_matrix_tile_sched
  import dca_matrix_tile_sched_pkg::*;
#(
  parameter int BW_ADDR         = DEF_BW_ADDR,
  parameter int BW_TILE_CNT     = DEF_BW_TILE_CNT,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int BW_OUTSTANDING  = DEF_BW_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      rstnn,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [BW_TILE_CNT-1:0]    job_m_tiles,
  input  logic [BW_TILE_CNT-1:0]    job_n_tiles,
  input  logic [BW_TILE_CNT-1:0]    job_k_tiles,
  input  logic [BW_ADDR-1:0]        job_a_base,
  input  logic [BW_ADDR-1:0]        job_b_base,
  input  logic [BW_ADDR-1:0]        job_c_base,
  input  logic [BW_ADDR-1:0]        job_a_mstride,
  input  logic [BW_ADDR-1:0]        job_a_kstride,
  input  logic [BW_ADDR-1:0]        job_b_kstride,
  input  logic [BW_ADDR-1:0]        job_b_nstride,
  input  logic [BW_ADDR-1:0]        job_c_mstride,
  input  logic [BW_ADDR-1:0]        job_c_nstride,
  input  logic                      abort,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [BW_ADDR-1:0]        inst_a_addr,
  output logic [BW_ADDR-1:0]        inst_b_addr,
  output logic [BW_ADDR-1:0]        inst_c_addr,
  output logic                      inst_acc,
  output logic                      inst_last,
  input  logic                      op_finish,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      finish_err,
  output logic [BW_OUTSTANDING-1:0] outstanding
);

  state_e state_q, state_d;
  logic [BW_OUTSTANDING-1:0] outstanding_q, outstanding_d;
  logic aborted_q, aborted_d, finish_err_q, finish_err_d;
  logic load, fire, gen_last, k_first, k_wrap, n_wrap, zero_dim;

  assign zero_dim = (job_m_tiles == '0) | (job_n_tiles == '0) | (job_k_tiles == '0);
  assign inst_valid = (state_q == ST_ISSUE) & ~abort &
                      (outstanding_q < BW_OUTSTANDING'(MAX_OUTSTANDING));
  assign fire        = inst_valid & inst_ready;
  assign job_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign inst_last   = (state_q == ST_ISSUE) & gen_last;
  assign inst_acc    = ~k_first;
  assign aborted     = aborted_q;
  assign finish_err  = finish_err_q;
  assign outstanding = outstanding_q;

  dca_matrix_tile_addr_gen #(
    .BW_ADDR     (BW_ADDR),
    .BW_TILE_CNT (BW_TILE_CNT)
  ) u_addr_gen (
    .clk         (clk),
    .rstnn       (rstnn),
    .load_i      (load),
    .advance_i   (fire),
    .m_tiles_i   (job_m_tiles),
    .n_tiles_i   (job_n_tiles),
    .k_tiles_i   (job_k_tiles),
    .a_base_i    (job_a_base),
    .b_base_i    (job_b_base),
    .c_base_i    (job_c_base),
    .a_mstride_i (job_a_mstride),
    .a_kstride_i (job_a_kstride),
    .b_kstride_i (job_b_kstride),
    .b_nstride_i (job_b_nstride),
    .c_mstride_i (job_c_mstride),
    .c_nstride_i (job_c_nstride),
    .a_addr_o    (inst_a_addr),
    .b_addr_o    (inst_b_addr),
    .c_addr_o    (inst_c_addr),
    .k_first_o   (k_first),
    .k_wrap_o    (k_wrap),
    .n_wrap_o    (n_wrap),
    .last_o      (gen_last)
  );

  always_comb begin
    state_d       = state_q;
    aborted_d     = aborted_q;
    finish_err_d  = finish_err_q;
    outstanding_d = outstanding_q;
    load          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          load         = 1'b1;
          aborted_d    = 1'b0;
          finish_err_d = 1'b0;
          state_d      = zero_dim ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (fire && gen_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (outstanding_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A stray finish pulse never underflows the counter; it only flags the error
    if (op_finish && outstanding_q == '0) finish_err_d = 1'b1;
    if (fire && !op_finish)
      outstanding_d = outstanding_q + BW_OUTSTANDING'(1);
    else if (!fire && op_finish && outstanding_q != '0)
      outstanding_d = outstanding_q - BW_OUTSTANDING'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      aborted_q     <= 1'b0;
      finish_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      aborted_q     <= aborted_d;
      finish_err_q  <= finish_err_d;
    end
  end

endmodule
